// File: rtl/dma_controller_pkg.sv
// rtl/dma_controller_pkg.sv - shared sizes and FSM state encoding for the M2 bus-master DMA engine
package dma_controller_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int BLOCK_SIZE      = 64;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int NUM_BLOCKS      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEGIN,
        ST_WAIT_CMD,
        ST_REQ,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE,
        ST_END
    } dma_state_t;

endpackage

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - M2 bus-master DMA engine; DMA_CYCLE_STEAL_EN releases the bus between blocks
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int WORD_SIZE       = dma_controller_pkg::WORD_SIZE,
    parameter int BLOCK_SIZE      = dma_controller_pkg::BLOCK_SIZE,
    parameter int WORDS_PER_BLOCK = dma_controller_pkg::WORDS_PER_BLOCK,
    parameter int NUM_BLOCKS      = dma_controller_pkg::NUM_BLOCKS
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  dev_ready,
    output logic [1:0]            dev_block_idx,
    input  logic [BLOCK_SIZE-1:0] dev_data,
    output logic                  dma_begin_interrupt,
    input  logic                  cmd_valid,
    input  logic [WORD_SIZE-1:0]  dma_set_address,
    output logic                  BR,
    input  logic                  BG,
    output logic                  writeM2,
    output logic [WORD_SIZE-1:0]  address2,
    output logic [BLOCK_SIZE-1:0] data2,
    input  logic                  M2busy,
    output logic                  dma_end_interrupt
);

    localparam logic [1:0] LAST_BLK = 2'(NUM_BLOCKS - 1);

    dma_state_t            state, state_next;
    logic [1:0]            blk, blk_next;
    logic [WORD_SIZE-1:0]  base, base_next;
    logic                  busy_seen, busy_seen_next;
    logic [BLOCK_SIZE-1:0] data_hold, data_hold_next;
    logic [WORD_SIZE-1:0]  blk_addr;

    // Address wraps modulo 2^WORD_SIZE by truncation of the sum.
    assign blk_addr = base + WORD_SIZE'(blk) * WORD_SIZE'(WORDS_PER_BLOCK);

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state     <= ST_IDLE;
            blk       <= '0;
            base      <= '0;
            busy_seen <= 1'b0;
            data_hold <= '0;
        end else begin
            state     <= state_next;
            blk       <= blk_next;
            base      <= base_next;
            busy_seen <= busy_seen_next;
            data_hold <= data_hold_next;
        end
    end

    always_comb begin
        state_next          = state;
        blk_next            = blk;
        base_next           = base;
        busy_seen_next      = busy_seen;
        data_hold_next      = data_hold;
        BR                  = 1'b0;
        writeM2             = 1'b0;
        address2            = '0;
        data2               = '0;
        dev_block_idx       = '0;
        dma_begin_interrupt = 1'b0;
        dma_end_interrupt   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (dev_ready) state_next = ST_BEGIN;
            end
            ST_BEGIN: begin
                dma_begin_interrupt = 1'b1;
                state_next          = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: begin
                if (cmd_valid) begin
                    base_next  = dma_set_address;
                    blk_next   = '0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                BR = 1'b1;
                if (BG) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                BR            = 1'b1;
                dev_block_idx = blk;
                // Losing the grant takes priority over waiting out a busy memory.
                if (!BG) begin
                    state_next = ST_REQ;
                end else if (!M2busy) begin
                    writeM2        = 1'b1;
                    address2       = blk_addr;
                    data2          = dev_data;
                    data_hold_next = dev_data;
                    busy_seen_next = 1'b0;
                    state_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                BR            = 1'b1;
                dev_block_idx = blk;
                address2      = blk_addr;
                data2         = data_hold;
                // Completion needs a busy phase first, so the idle write cycle is not mistaken for done.
                if (M2busy) begin
                    busy_seen_next = 1'b1;
                end else if (busy_seen) begin
                    if (blk == LAST_BLK) begin
                        state_next = ST_END;
                    end else begin
                        blk_next = blk + 2'd1;
`ifdef DMA_CYCLE_STEAL_EN
                        state_next = ST_RELEASE;
`else
                        state_next = ST_ISSUE;
`endif
                    end
                end
            end
`ifdef DMA_CYCLE_STEAL_EN
            ST_RELEASE: begin
                state_next = ST_REQ;
            end
`endif
            ST_END: begin
                dma_end_interrupt = 1'b1;
                state_next        = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_controller.sv
// tb/tb_dma_controller.sv - randomized self-checking bench for dma_controller against a transfer-level model
module tb_dma_controller;

    localparam int NB = 3;
`ifdef DMA_CYCLE_STEAL_EN
    localparam int EXP_GAPS = NB - 1;
`else
    localparam int EXP_GAPS = 0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        dev_ready = 1'b0;
    logic [1:0]  dev_block_idx;
    logic [63:0] dev_data;
    logic        dma_begin_interrupt;
    logic        cmd_valid = 1'b0;
    logic [15:0] dma_set_address = '0;
    logic        BR;
    logic        BG = 1'b0;
    logic        writeM2;
    logic [15:0] address2;
    logic [63:0] data2;
    logic        M2busy = 1'b0;
    logic        dma_end_interrupt;

    logic [63:0] dev_mem [4];
    assign dev_data = dev_mem[dev_block_idx];

    dma_controller dut (
        .Clk                 (Clk),
        .Reset_N             (Reset_N),
        .dev_ready           (dev_ready),
        .dev_block_idx       (dev_block_idx),
        .dev_data            (dev_data),
        .dma_begin_interrupt (dma_begin_interrupt),
        .cmd_valid           (cmd_valid),
        .dma_set_address     (dma_set_address),
        .BR                  (BR),
        .BG                  (BG),
        .writeM2             (writeM2),
        .address2            (address2),
        .data2               (data2),
        .M2busy              (M2busy),
        .dma_end_interrupt   (dma_end_interrupt)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    int begin_cnt = 0, end_cnt = 0, wr_bg0 = 0, br_low = 0, br_gaps = 0;
    int busy_cnt = 0, busy_len = 3, br_age = 0, bg_delay = 0;
    bit in_xfer = 0, bg_en = 1, br_prev = 0;
    logic [15:0] wa_q [$];
    logic [63:0] wd_q [$];
    logic [15:0] exp_a [$];
    logic [63:0] exp_d [$];

    // Bus observer: samples just before each rising edge.
    always @(negedge Clk) begin
        #4;
        if (!Reset_N) begin
            in_xfer = 0;
            br_prev = 0;
        end else begin
            if (dma_begin_interrupt) begin_cnt++;
            if (writeM2) begin
                wa_q.push_back(address2);
                wd_q.push_back(data2);
                if (!BG) wr_bg0++;
                busy_cnt = busy_len;
            end
            if (BR) in_xfer = 1;
            if (in_xfer && !BR && !dma_end_interrupt) begin
                br_low++;
                if (br_prev) br_gaps++;
            end
            if (dma_end_interrupt) begin
                end_cnt++;
                in_xfer = 0;
            end
            br_prev = BR;
        end
    end

    // Memory: busy for busy_len cycles starting the cycle after each write.
    always @(negedge Clk) begin
        if (busy_cnt > 0) begin
            M2busy = 1'b1;
            busy_cnt--;
        end else begin
            M2busy = 1'b0;
        end
    end

    // CPU arbiter: grants bg_delay cycles after the request appears, while bg_en allows.
    always @(negedge Clk) begin
        if (in_xfer) br_age++;
        else br_age = 0;
        BG = bg_en && in_xfer && (br_age > bg_delay);
    end

    task automatic clear_obs();
        begin_cnt = 0; end_cnt = 0; wr_bg0 = 0; br_low = 0; br_gaps = 0;
        wa_q.delete(); wd_q.delete();
    endtask

    task automatic model_transfer(input logic [15:0] base);
        exp_a.delete(); exp_d.delete();
        for (int k = 0; k < NB; k++) begin
            dev_mem[k] = {$urandom, $urandom};
            exp_a.push_back(base + 16'(4 * k));
            exp_d.push_back(dev_mem[k]);
        end
    endtask

    task automatic start_xfer(input logic [15:0] base);
        int n = 0;
        int b0 = begin_cnt;
        dev_ready = 1'b1;
        @(negedge Clk);
        dev_ready = 1'b0;
        while (begin_cnt == b0 && n < 20) begin @(negedge Clk); n++; end
        checks++;
        if (begin_cnt == b0) begin
            failures++;
            $display("FAIL begin_timeout got=none required=begin pulse");
        end
        cmd_valid = 1'b1;
        dma_set_address = base;
        @(negedge Clk);
        cmd_valid = 1'b0;
        dma_set_address = 16'($urandom);
    endtask

    task automatic wait_end();
        int n = 0;
        int e0 = end_cnt;
        while (end_cnt == e0 && n < 400) begin @(negedge Clk); n++; end
        checks++;
        if (end_cnt == e0) begin
            failures++;
            $display("FAIL end_timeout got=none required=end pulse");
        end
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (BR !== 1'b0) begin failures++; $display("FAIL reset_br got=%b required=0", BR); end
        checks++; if (writeM2 !== 1'b0) begin failures++; $display("FAIL reset_write got=%b required=0", writeM2); end
        checks++; if (address2 !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h required=0", address2); end
        checks++; if (data2 !== 64'h0) begin failures++; $display("FAIL reset_data got=%h required=0", data2); end
        checks++; if (dev_block_idx !== 2'd0) begin failures++; $display("FAIL reset_idx got=%0d required=0", dev_block_idx); end
        checks++; if ({dma_begin_interrupt, dma_end_interrupt} !== 2'b00) begin
            failures++; $display("FAIL reset_irq got=%b required=00", {dma_begin_interrupt, dma_end_interrupt});
        end
        Reset_N = 1'b1;
        repeat (2) @(negedge Clk);
        checks++; if (BR !== 1'b0) begin failures++; $display("FAIL idle_br got=%b required=0", BR); end
    endtask

    task automatic test_basic();
        clear_obs(); bg_delay = 0; busy_len = 3; bg_en = 1;
        model_transfer(16'h01F4);
        start_xfer(16'h01F4);
        wait_end();
        repeat (3) @(negedge Clk);
        checks++; if (begin_cnt != 1) begin failures++; $display("FAIL basic_begins got=%0d required=1", begin_cnt); end
        checks++; if (end_cnt != 1) begin failures++; $display("FAIL basic_ends got=%0d required=1", end_cnt); end
        checks++; if (wa_q.size() != NB) begin failures++; $display("FAIL basic_writes got=%0d required=%0d", wa_q.size(), NB); end
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            checks++; if (wa_q[k] !== exp_a[k]) begin failures++; $display("FAIL basic_addr%0d got=%h required=%h", k, wa_q[k], exp_a[k]); end
            checks++; if (wd_q[k] !== exp_d[k]) begin failures++; $display("FAIL basic_data%0d got=%h required=%h", k, wd_q[k], exp_d[k]); end
        end
        checks++; if (BR !== 1'b0) begin failures++; $display("FAIL basic_br_after got=%b required=0", BR); end
        checks++; if (br_low != EXP_GAPS) begin failures++; $display("FAIL basic_br_low got=%0d required=%0d", br_low, EXP_GAPS); end
        checks++; if (br_gaps != EXP_GAPS) begin failures++; $display("FAIL basic_br_gaps got=%0d required=%0d", br_gaps, EXP_GAPS); end
    endtask

    task automatic test_delayed_grant();
        logic [15:0] base = 16'($urandom) & 16'hFFF0;
        clear_obs(); bg_delay = 10; busy_len = int'($urandom_range(1, 4)); bg_en = 1;
        model_transfer(base);
        start_xfer(base);
        wait_end();
        checks++; if (wr_bg0 != 0) begin failures++; $display("FAIL delay_write_no_grant got=%0d required=0", wr_bg0); end
        checks++; if (br_low != EXP_GAPS) begin failures++; $display("FAIL delay_br_low got=%0d required=%0d", br_low, EXP_GAPS); end
        checks++; if (wa_q.size() != NB) begin failures++; $display("FAIL delay_writes got=%0d required=%0d", wa_q.size(), NB); end
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            checks++; if (wa_q[k] !== exp_a[k]) begin failures++; $display("FAIL delay_addr%0d got=%h required=%h", k, wa_q[k], exp_a[k]); end
            checks++; if (wd_q[k] !== exp_d[k]) begin failures++; $display("FAIL delay_data%0d got=%h required=%h", k, wd_q[k], exp_d[k]); end
        end
        bg_delay = 0;
    endtask

    task automatic test_grant_withdrawn();
        int n = 0;
        logic [15:0] base = 16'($urandom);
        clear_obs(); bg_delay = 0; busy_len = 3; bg_en = 1;
        model_transfer(base);
        start_xfer(base);
        while (wa_q.size() < 2 && n < 200) begin @(negedge Clk); n++; end
        bg_en = 0;
        repeat (10) @(negedge Clk);
        checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL withdraw_writes_held got=%0d required=2", wa_q.size()); end
        checks++; if (BR !== 1'b1) begin failures++; $display("FAIL withdraw_br got=%b required=1", BR); end
        bg_en = 1;
        wait_end();
        checks++; if (wr_bg0 != 0) begin failures++; $display("FAIL withdraw_write_no_grant got=%0d required=0", wr_bg0); end
        checks++; if (wa_q.size() != NB) begin failures++; $display("FAIL withdraw_writes got=%0d required=%0d", wa_q.size(), NB); end
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            checks++; if (wa_q[k] !== exp_a[k]) begin failures++; $display("FAIL withdraw_addr%0d got=%h required=%h", k, wa_q[k], exp_a[k]); end
            checks++; if (wd_q[k] !== exp_d[k]) begin failures++; $display("FAIL withdraw_data%0d got=%h required=%h", k, wd_q[k], exp_d[k]); end
        end
    endtask

    task automatic test_wrap();
        clear_obs(); busy_len = int'($urandom_range(1, 5));
        model_transfer(16'hFFFC);
        start_xfer(16'hFFFC);
        wait_end();
        checks++; if (wa_q.size() != NB) begin failures++; $display("FAIL wrap_writes got=%0d required=%0d", wa_q.size(), NB); end
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            checks++; if (wa_q[k] !== exp_a[k]) begin failures++; $display("FAIL wrap_addr%0d got=%h required=%h", k, wa_q[k], exp_a[k]); end
            checks++; if (wd_q[k] !== exp_d[k]) begin failures++; $display("FAIL wrap_data%0d got=%h required=%h", k, wd_q[k], exp_d[k]); end
        end
    endtask

    task automatic test_ignored_events();
        logic [15:0] base = 16'h0400 + 16'($urandom_range(0, 255));
        clear_obs(); busy_len = int'($urandom_range(1, 3));
        model_transfer(base);
        start_xfer(base);
        fork
            wait_end();
            begin
                int n = 0;
                while (wa_q.size() < 1 && n < 200) begin @(negedge Clk); n++; end
                while (wa_q.size() < NB && n < 200) begin
                    dev_ready = 1'b1; cmd_valid = 1'b1; dma_set_address = ~base;
                    @(negedge Clk); n++;
                end
                dev_ready = 1'b0; cmd_valid = 1'b0;
            end
        join
        repeat (6) @(negedge Clk);
        checks++; if (begin_cnt != 1) begin failures++; $display("FAIL ignore_begins got=%0d required=1", begin_cnt); end
        checks++; if (BR !== 1'b0) begin failures++; $display("FAIL ignore_br_idle got=%b required=0", BR); end
        checks++; if (wa_q.size() != NB) begin failures++; $display("FAIL ignore_writes got=%0d required=%0d", wa_q.size(), NB); end
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            checks++; if (wa_q[k] !== exp_a[k]) begin failures++; $display("FAIL ignore_addr%0d got=%h required=%h", k, wa_q[k], exp_a[k]); end
        end
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        logic [15:0] base = 16'($urandom);
        clear_obs(); busy_len = 4;
        model_transfer(base);
        start_xfer(base);
        while (wa_q.size() < 2 && n < 200) begin @(negedge Clk); n++; end
        @(negedge Clk);
        Reset_N = 1'b0;
        #1;
        checks++; if (BR !== 1'b0) begin failures++; $display("FAIL midreset_br got=%b required=0", BR); end
        checks++; if (writeM2 !== 1'b0) begin failures++; $display("FAIL midreset_write got=%b required=0", writeM2); end
        checks++; if (address2 !== 16'h0) begin failures++; $display("FAIL midreset_addr got=%h required=0", address2); end
        checks++; if (data2 !== 64'h0) begin failures++; $display("FAIL midreset_data got=%h required=0", data2); end
        busy_cnt = 0;
        repeat (2) @(negedge Clk);
        Reset_N = 1'b1;
        @(negedge Clk);
        clear_obs(); busy_len = 2;
        base = 16'($urandom);
        model_transfer(base);
        start_xfer(base);
        wait_end();
        checks++; if (wa_q.size() != NB) begin failures++; $display("FAIL restart_writes got=%0d required=%0d", wa_q.size(), NB); end
        for (int k = 0; k < NB && k < wa_q.size(); k++) begin
            checks++; if (wa_q[k] !== exp_a[k]) begin failures++; $display("FAIL restart_addr%0d got=%h required=%h", k, wa_q[k], exp_a[k]); end
            checks++; if (wd_q[k] !== exp_d[k]) begin failures++; $display("FAIL restart_data%0d got=%h required=%h", k, wd_q[k], exp_d[k]); end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) dev_mem[k] = '0;
        test_reset();
        test_basic();
        test_delayed_grant();
        test_grant_withdrawn();
        test_wrap();
        test_ignored_events();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1);
    end

endmodule
